// File: rtl/timer_periph_pkg.sv
// ============================================================================
// timer_periph_pkg : register map and TCON bit positions for timer_periph
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package timer_periph_pkg;

  typedef enum logic [1:0] {
    ADDR_TH   = 2'd0,
    ADDR_TL   = 2'd1,
    ADDR_TCON = 2'd2,
    ADDR_RSVD = 2'd3
  } addr_e;

  localparam int TCON_EN  = 0;
  localparam int TCON_IEN = 1;
  localparam int TCON_IRQ = 2;
  localparam int TCON_W   = 3;

endpackage

`default_nettype wire

// File: rtl/edge_sync.sv
// ============================================================================
// edge_sync : tick_clk synchronizer plus rising-edge detector (one-clk pulse)
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_clk,
  output logic cnt_pulse
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES:0]   fill_q, fill_d;
  logic                   prev_q, prev_d;

  // fill_q marks when prev_q holds a real synchronized sample, so a level that
  // was already high across reset is not mistaken for a fresh rising edge.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], tick_clk};
    fill_d    = {fill_q[SYNC_STAGES-1:0], 1'b1};
    prev_d    = sync_q[SYNC_STAGES-1];
    cnt_pulse = sync_q[SYNC_STAGES-1] & ~prev_q & fill_q[SYNC_STAGES];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      fill_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      fill_q <= fill_d;
      prev_q <= prev_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/timer_periph.sv
// ============================================================================
// timer_periph : auto-reload timer (TH reload, TL count, TCON control/irq)
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module timer_periph
  import timer_periph_pkg::*;
#(
  parameter int W           = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick_clk,
  input  logic [1:0]   addr,
  input  logic         wr_en,
  input  logic [W-1:0] wdata,
  input  logic         rd_en,
  output logic [W-1:0] rdata,
  output logic         rvalid,
  output logic         irq
);

  logic [W-1:0]      th_q, th_d;
  logic [W-1:0]      tl_q, tl_d;
  logic [TCON_W-1:0] tcon_q, tcon_d;
  logic [W-1:0]      rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;

  logic cnt_pulse;
  logic wr_th, wr_tl, wr_tcon;
  logic count_en, overflow;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk      (clk),
    .reset    (reset),
    .tick_clk (tick_clk),
    .cnt_pulse(cnt_pulse)
  );

  always_comb begin
    wr_th    = wr_en && (addr_e'(addr) == ADDR_TH);
    wr_tl    = wr_en && (addr_e'(addr) == ADDR_TL);
    wr_tcon  = wr_en && (addr_e'(addr) == ADDR_TCON);
    count_en = cnt_pulse && tcon_q[TCON_EN];
    overflow = count_en && (tl_q == {W{1'b1}});

    th_d = wr_th ? wdata : th_q;

    // A bus write to TL beats a coincident count; the count is lost.
    tl_d = tl_q;
    if (wr_tl) begin
      tl_d = wdata;
    end else if (overflow) begin
      tl_d = th_q;
    end else if (count_en) begin
      tl_d = tl_q + W'(1);
    end

    // Overflow set is applied after the W1C clear so that set wins.
    tcon_d = tcon_q;
    if (wr_tcon) begin
      tcon_d[TCON_EN]  = wdata[TCON_EN];
      tcon_d[TCON_IEN] = wdata[TCON_IEN];
      if (wdata[TCON_IRQ]) begin
        tcon_d[TCON_IRQ] = 1'b0;
      end
    end
    if (overflow && tcon_q[TCON_IEN]) begin
      tcon_d[TCON_IRQ] = 1'b1;
    end

    rvalid_d = rd_en;
    rdata_d  = rdata_q;
    if (rd_en) begin
      case (addr_e'(addr))
        ADDR_TH:   rdata_d = th_q;
        ADDR_TL:   rdata_d = tl_q;
        ADDR_TCON: rdata_d = {{(W-TCON_W){1'b0}}, tcon_q};
        default:   rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q     <= '0;
      tl_q     <= '0;
      tcon_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      th_q     <= th_d;
      tl_q     <= tl_d;
      tcon_q   <= tcon_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign irq    = tcon_q[TCON_IRQ];

endmodule

`default_nettype wire

// File: tb/tb_timer_periph.sv
// ============================================================================
// tb_timer_periph : directed scoreboard bench for timer_periph
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_timer_periph;

  localparam int W = 32;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         tick_clk;
  logic [1:0]   addr;
  logic         wr_en;
  logic [W-1:0] wdata;
  logic         rd_en;
  logic [W-1:0] rdata;
  logic         rvalid;
  logic         irq;

  timer_periph #(
    .W          (W),
    .SYNC_STAGES(S)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tick_clk(tick_clk),
    .addr    (addr),
    .wr_en   (wr_en),
    .wdata   (wdata),
    .rd_en   (rd_en),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] exp;
    string        name;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  // Monitor: every rvalid pulse is matched against the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && rvalid) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rvalid: rdata=%h, no read outstanding", rdata);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        tests++;
        if (rdata !== e.exp) begin
          fails++;
          $display("FAIL %s: got %h, expected %h", e.name, rdata, e.exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    cyc(1);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [W-1:0] exp, input string name);
    exp_t e;
    e.exp  = exp;
    e.name = name;
    sbq.push_back(e);
    addr  = a;
    rd_en = 1'b1;
    cyc(1);
    rd_en = 1'b0;
  endtask

  task automatic tick();
    tick_clk = 1'b1;
    cyc(S + 3);
    tick_clk = 1'b0;
    cyc(S + 2);
  endtask

  initial begin
    reset    = 1'b1;
    tick_clk = 1'b0;
    addr     = 2'd0;
    wr_en    = 1'b0;
    wdata    = '0;
    rd_en    = 1'b0;
    cyc(3);
    chk("reset_rvalid", W'(rvalid), 0);
    chk("reset_rdata", rdata, 0);
    chk("reset_irq", W'(irq), 0);
    reset = 1'b0;
    cyc(1);
    rd(2'd0, 0, "reset_th");
    rd(2'd1, 0, "reset_tl");
    rd(2'd2, 0, "reset_tcon");

    // Reload sequence with irq enabled
    wr(2'd0, 32'hFFFF_FFF0);
    wr(2'd1, 32'hFFFF_FFFD);
    wr(2'd2, 32'h3);
    tick();
    rd(2'd1, 32'hFFFF_FFFE, "cnt_fe");
    tick();
    rd(2'd1, 32'hFFFF_FFFF, "cnt_ff");
    chk("irq_before_ovf", W'(irq), 0);
    tick();
    rd(2'd1, 32'hFFFF_FFF0, "reload_th");
    rd(2'd2, 32'h7, "tcon_irq_set");
    chk("irq_after_ovf", W'(irq), 1);
    tick();
    rd(2'd1, 32'hFFFF_FFF1, "cnt_after_reload");
    cyc(2);
    chk("rdata_hold", rdata, 32'hFFFF_FFF1);

    // Latency: back-to-back reads sample TL before each edge after the rise
    wr(2'd1, 32'h0);
    tick_clk = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      rd(2'd1, (k >= S + 2) ? 32'h1 : 32'h0, $sformatf("latency_k%0d", k));
    end
    cyc(95);
    rd(2'd1, 32'h1, "long_high_one_inc");
    tick_clk = 1'b0;
    cyc(S + 2);

    // Overflow with irq disabled, then counting disabled
    wr(2'd2, 32'h4);
    wr(2'd0, 32'h10);
    wr(2'd1, 32'hFFFF_FFFF);
    wr(2'd2, 32'h1);
    tick();
    rd(2'd1, 32'h10, "reload_noirq");
    rd(2'd2, 32'h1, "tcon_noirq");
    wr(2'd2, 32'h0);
    repeat (5) tick();
    rd(2'd1, 32'h10, "disabled_no_count");

    // Pending irq, W1C coincident with overflow: set wins
    wr(2'd2, 32'h3);
    wr(2'd1, 32'hFFFF_FFFF);
    tick();
    rd(2'd2, 32'h7, "irq_pending");
    wr(2'd1, 32'hFFFF_FFFF);
    tick_clk = 1'b1;
    cyc(S);
    wr(2'd2, 32'h7);
    cyc(3);
    tick_clk = 1'b0;
    cyc(S + 2);
    rd(2'd2, 32'h7, "set_beats_clear");
    rd(2'd1, 32'h10, "reload_at_clear");
    wr(2'd2, 32'h7);
    rd(2'd2, 32'h3, "w1c_keeps_enables");
    chk("irq_cleared", W'(irq), 0);

    // Clearing IEN keeps a pending irq
    wr(2'd1, 32'hFFFF_FFFF);
    tick();
    wr(2'd2, 32'h1);
    rd(2'd2, 32'h5, "ien_clear_keeps_irq");
    wr(2'd2, 32'h7);

    // TL write coincident with pulse: write wins
    wr(2'd1, 32'h100);
    tick_clk = 1'b1;
    cyc(S);
    wr(2'd1, 32'h1234);
    cyc(3);
    tick_clk = 1'b0;
    cyc(S + 2);
    rd(2'd1, 32'h1234, "write_beats_count");
    wr(2'd3, 32'hDEAD_BEEF);
    rd(2'd3, 32'h0, "rsvd_read_zero");
    rd(2'd0, 32'h10, "rsvd_write_no_effect");

    // Simultaneous read and write: read returns pre-write value
    addr  = 2'd1;
    wdata = 32'h55;
    wr_en = 1'b1;
    rd(2'd1, 32'h1234, "rdwr_pre_value");
    wr_en = 1'b0;
    rd(2'd1, 32'h55, "rdwr_post_value");

    // Reset between tick rise and pulse, tick level still high on release
    cyc(3);
    wr(2'd1, 32'h5);
    tick_clk = 1'b1;
    cyc(1);
    reset = 1'b1;
    cyc(2);
    chk("midreset_irq", W'(irq), 0);
    chk("midreset_rdata", rdata, 0);
    reset = 1'b0;
    wr(2'd2, 32'h1);
    cyc(S + 6);
    rd(2'd1, 32'h0, "no_inc_after_reset");
    tick_clk = 1'b0;
    cyc(S + 2);
    tick();
    rd(2'd1, 32'h1, "inc_on_fresh_rise");

    cyc(4);
    chk("scoreboard_drained", W'(sbq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
